// File: rtl/fib_stream_gen.sv
// Fibonacci-class sequence source with loadable seeds, a programmable term count,
// a valid/ready output stream, and wrap detection with optional early stop.
module fib_stream_gen #(
  parameter int unsigned WIDTH       = 12,
  parameter int unsigned CNT_W       = 8,
  parameter bit          STOP_ON_OVF = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] seed0,
  input  logic [WIDTH-1:0] seed1,
  input  logic [CNT_W-1:0] n_terms,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] out_index,
  output logic             out_last,
  output logic             busy,
  output logic             done,
  output logic             overflow
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_prev, r_cur;
  logic             r_prev_w, r_cur_w;
  logic [CNT_W-1:0] r_rem, r_index;
  logic             r_ovf;

  logic [WIDTH:0]   w_sum;
  logic             w_load, w_xfer, w_last, w_ovf_set, w_ovf_clr;

  assign w_sum = {1'b0, r_cur} + {1'b0, r_prev};

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_xfer      = 1'b0;
    w_last      = 1'b0;
    w_ovf_set   = 1'b0;
    w_ovf_clr   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_ovf_clr = 1'b1;
          if (n_terms != '0) begin
            w_load      = 1'b1;
            w_state_nxt = S_RUN;
          end else begin
            w_state_nxt = S_DONE;
          end
        end
      end
      S_RUN: begin
        w_last = (r_rem == CNT_W'(1)) || (STOP_ON_OVF && r_cur_w);
        w_xfer = out_ready;
        // Early stop flags overflow only when the count did not end the stream itself.
        if (STOP_ON_OVF) w_ovf_set = w_xfer && r_cur_w && (r_rem != CNT_W'(1));
        else             w_ovf_set = w_xfer && r_prev_w;
        if (w_xfer && w_last) w_state_nxt = S_DONE;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_prev   <= '0;
      r_cur    <= '0;
      r_prev_w <= 1'b0;
      r_cur_w  <= 1'b0;
      r_rem    <= '0;
      r_index  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load) begin
        r_prev   <= seed0;
        r_cur    <= seed1;
        r_prev_w <= 1'b0;
        r_cur_w  <= 1'b0;
        r_rem    <= n_terms;
        r_index  <= '0;
      end else if (w_xfer) begin
        r_prev   <= r_cur;
        r_prev_w <= r_cur_w;
        r_cur    <= w_sum[WIDTH-1:0];
        r_cur_w  <= w_sum[WIDTH] | r_cur_w | r_prev_w;
        r_rem    <= r_rem - CNT_W'(1);
        r_index  <= r_index + CNT_W'(1);
      end
      if (w_ovf_clr)      r_ovf <= 1'b0;
      else if (w_ovf_set) r_ovf <= 1'b1;
    end
  end

  assign out_valid = (r_state == S_RUN);
  assign out_data  = r_prev;
  assign out_index = r_index;
  assign out_last  = w_last;
  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_DONE);
  assign overflow  = r_ovf;

endmodule

// File: doc/fib_stream_gen.md
Name: fib_stream_gen

Overview:
Parametrised Fibonacci-class sequence generator: the next generation of the team's free-running 12-bit Fibonacci counter.
- Adds loadable seeds (Fibonacci, Lucas, arbitrary), a programmable term count, a valid/ready output stream with back-pressure, and overflow detection with optional truncation.
- Sits as a streaming source feeding datapath/ALU exercises and testbench stimulus.

Parameters:
WIDTH, 12, bit width of seeds and output terms
CNT_W, 8, width of n_terms and out_index
STOP_ON_OVF, 1, 1 = end the stream before the first wrapped term; 0 = emit wrapped (mod 2^WIDTH) terms and only flag them

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-high
start  input  1  one-cycle request to begin a sequence; sampled only in IDLE
seed0  input  WIDTH  term 0; latched on accepted start
seed1  input  WIDTH  term 1; latched on accepted start
n_terms  input  CNT_W  number of terms to emit; latched on accepted start
out_valid  output  1  out_data holds a valid term
out_ready  input  1  consumer accepts the term this cycle
out_data  output  WIDTH  current term
out_index  output  CNT_W  index of current term, starting at 0
out_last  output  1  current term is the final one of the sequence
busy  output  1  high in RUN and DONE
done  output  1  one-cycle pulse marking sequence completion
overflow  output  1  sticky wrap flag; cleared on accepted start

Behaviour:
- Reset (async, immediate): state=IDLE. out_valid, out_last, busy, done, overflow = 0. out_data = 0, out_index = 0. Internal prev/cur/wrap bits/remaining = 0.
- Internal registers:
  - prev drives out_data; cur is the next term.
  - prev_w / cur_w are wrap tags. A term is "wrapped" if its true sum is >= 2^WIDTH, or it was derived from a wrapped term.
  - remaining counts terms still to emit.
- Transfer: a transfer occurs in any cycle where out_valid && out_ready.
- IDLE:
  - busy=0, out_valid=0.
  - start && n_terms!=0: load prev=seed0, cur=seed1, prev_w=cur_w=0, remaining=n_terms, out_index=0, overflow=0; go to RUN.
  - start && n_terms==0: clear overflow; go to DONE. No beats are emitted.
- RUN:
  - out_valid=1, registered; the first term is valid in the cycle after start.
  - out_last = (remaining==1) || (STOP_ON_OVF && cur_w).
  - On transfer:
    - prev<=cur, prev_w<=cur_w.
    - cur<=(cur+prev) mod 2^WIDTH.
    - cur_w<=carry|cur_w|prev_w.
    - remaining--, out_index++.
    - If out_last: go to DONE.
  - No transfer: all outputs hold stable; out_valid never drops while waiting.
- DONE: busy=1, out_valid=0, done=1 for exactly one cycle, then IDLE.
- Overflow:
  - STOP_ON_OVF=0: set in the cycle after the first wrapped term is transferred.
  - STOP_ON_OVF=1: set in the cycle after a transfer that ended the stream because cur_w=1. Not set if remaining==1 terminated the stream first.
  - Once set, holds until the next accepted start.
- Start while busy: ignored. No effect on the stream, seeds or overflow.
- Throughput: one term per cycle with out_ready held high. Latency from start to first valid is 1 cycle.
- Arithmetic: unsigned, modulo 2^WIDTH. The carry out of the WIDTH-bit add is the only overflow source.
- Reset mid-sequence: out_valid drops asynchronously and no done pulse is produced. The next start begins a fresh sequence.

Test Plan:
- Fibonacci, WIDTH=12, seeds 0/1, n_terms=10, out_ready=1 -> terms 0,1,1,2,3,5,8,13,21,34 in 10 consecutive cycles; out_last on index 9; done pulses once; overflow=0.
- Lucas, seeds 2/1, n_terms=5, out_ready toggling 1,0,1,0… -> 2,1,3,4,7. Each term held stable across stall cycles; out_index tracks 0..4.
- STOP_ON_OVF=1, WIDTH=12, seeds 0/1, n_terms=30 -> 19 terms (indices 0..18); last term 2584 with out_last=1; overflow=1 after the final transfer.
- STOP_ON_OVF=0, same stimulus -> index 19 emits 85 (4181 mod 4096); overflow rises the cycle after index 19 transfers; 30 terms total.
- n_terms=0 -> no out_valid; done pulses one cycle later. A start pulsed mid-RUN is ignored: the stream continues unchanged.
- rst asserted after index 3 while out_ready=0 -> out_valid, busy and overflow go to 0 immediately with no done pulse. A fresh start then restarts at index 0.
